// File: rtl/video_stream_source_pkg.sv
// Shared widths, pattern codes and LFSR helper for the video stream source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vid_pkg;

    localparam int VID_X_W   = 11;
    localparam int VID_Y_W   = 10;
    localparam int VID_PIX_W = 8;

    localparam logic [VID_PIX_W-1:0] LFSR_SEED = 8'hA5;
    // Galois taps for x^8+x^6+x^5+x^4+1 in a right-shifting register.
    localparam logic [VID_PIX_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_LFSR  = 2'd3
    } pat_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vid_state_e;

    function automatic logic [VID_PIX_W-1:0] lfsr_next(input logic [VID_PIX_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/video_stream_source_timing_gen.sv
// Pixel-tick divider, h/v raster counters and IDLE/RUN control with vsync/active decode.
// Latency: decode is combinational from the counter registers; the top registers it.
// Backpressure: none; enable is only honoured at a frame boundary.
module vid_timing_gen
    import vid_pkg::*;
#(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int H_BLANK   = 160,
    parameter int V_BLANK   = 25,
    parameter int VSYNC_LEN = 5,
    parameter int CLKEN_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    output logic        o_tick,
    output logic        o_frame_start,
    output logic        o_run,
    output logic        o_vsync,
    output logic        o_act,
    output logic [11:0] o_h,
    output logic [10:0] o_v
);

    localparam int H_TOTAL = IMG_HDISP + H_BLANK;
    localparam int V_TOTAL = IMG_VDISP + V_BLANK;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END  = 12'(IMG_HDISP);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_BEG  = 11'(V_BLANK);
    localparam logic [10:0] V_SYNC_END = 11'(VSYNC_LEN);
    localparam logic [3:0]  DIV_LAST   = 4'(CLKEN_DIV - 1);

    vid_state_e  r_state, w_state_nxt;
    logic [3:0]  r_div;
    logic [11:0] r_h, w_h_nxt;
    logic [10:0] r_v, w_v_nxt;
    logic        w_tick;
    logic        w_frame_start;

    assign w_tick = (r_div == DIV_LAST);

    // Free-running pixel-tick divider, also runs while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else begin
            r_div <= w_tick ? 4'd0 : r_div + 4'd1;
        end
    end

    // State and raster counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    // Next state: counters move on ticks; enable is only looked at when a frame could begin.
    always_comb begin
        w_state_nxt   = r_state;
        w_h_nxt       = r_h;
        w_v_nxt       = r_v;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && i_enable) begin
                    w_state_nxt   = ST_RUN;
                    w_h_nxt       = '0;
                    w_v_nxt       = '0;
                    w_frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    if (r_h == H_LAST) begin
                        w_h_nxt = '0;
                        if (r_v == V_LAST) begin
                            w_v_nxt = '0;
                            if (i_enable) begin
                                w_frame_start = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_v_nxt = r_v + 11'd1;
                        end
                    end else begin
                        w_h_nxt = r_h + 12'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_tick        = w_tick;
    assign o_frame_start = w_frame_start;
    assign o_run         = (r_state == ST_RUN);
    assign o_vsync       = o_run && (r_v < V_SYNC_END);
    assign o_act         = o_run && (r_v >= V_ACT_BEG) && (r_h < H_ACT_END);
    assign o_h           = r_h;
    assign o_v           = r_v;

endmodule

// File: rtl/video_stream_source.sv
// Raster pattern source driving the per_frame_* vsync/href/clken stream with luma and coordinates.
// Latency: all outputs are registered, one clock after the raster counter state they describe.
// Backpressure: none; frames run to completion, enable/pattern_sel take effect at frame start.
module video_stream_source
    import vid_pkg::*;
#(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int H_BLANK   = 160,
    parameter int V_BLANK   = 25,
    parameter int VSYNC_LEN = 5,
    parameter int CLKEN_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    output logic                 post_frame_vsync,
    output logic                 post_frame_href,
    output logic                 post_frame_clken,
    output logic [VID_PIX_W-1:0] post_img_Y,
    output logic [VID_X_W-1:0]   post_setx,
    output logic [VID_Y_W-1:0]   post_sety,
    output logic                 frame_done
);

    if (IMG_HDISP < 1 || IMG_HDISP > 2047 || IMG_VDISP < 1 || IMG_VDISP > 1023) begin : g_err_disp
        $error("video_stream_source: active size out of range");
    end
    if (H_BLANK < 1 || V_BLANK < 2 || VSYNC_LEN < 1 || VSYNC_LEN > V_BLANK - 1) begin : g_err_blank
        $error("video_stream_source: blanking/vsync configuration invalid");
    end
    if (CLKEN_DIV < 1 || CLKEN_DIV > 15 || IMG_HDISP + H_BLANK > 4096 || IMG_VDISP + V_BLANK > 2048) begin : g_err_div
        $error("video_stream_source: divider or raster totals out of range");
    end

    localparam logic [VID_X_W-1:0] X_LAST    = VID_X_W'(IMG_HDISP - 1);
    localparam logic [VID_Y_W-1:0] Y_LAST    = VID_Y_W'(IMG_VDISP - 1);
    localparam logic [10:0]        V_BLANK_W = 11'(V_BLANK);

    logic                 w_tick, w_frame_start, w_run, w_vsync, w_act, w_pix_en;
    logic [11:0]          w_h;
    logic [10:0]          w_v;
    logic [VID_X_W-1:0]   w_x;
    logic [VID_Y_W-1:0]   w_y;
    logic [VID_PIX_W-1:0] w_pix;

    logic                 r_vsync, r_href, r_clken, r_frame_done;
    logic [VID_PIX_W-1:0] r_img_y, r_lfsr;
    logic [VID_X_W-1:0]   r_setx;
    logic [VID_Y_W-1:0]   r_sety;
    pat_e                 r_pat;

    vid_timing_gen #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_BLANK   (H_BLANK),
        .V_BLANK   (V_BLANK),
        .VSYNC_LEN (VSYNC_LEN),
        .CLKEN_DIV (CLKEN_DIV)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .o_tick        (w_tick),
        .o_frame_start (w_frame_start),
        .o_run         (w_run),
        .o_vsync       (w_vsync),
        .o_act         (w_act),
        .o_h           (w_h),
        .o_v           (w_v)
    );

    assign w_x      = VID_X_W'(w_h);
    assign w_y      = VID_Y_W'(w_v - V_BLANK_W);
    assign w_pix_en = w_act && w_tick;

    // Pixel value for the current active coordinate under the pattern latched at frame start.
    always_comb begin
        w_pix = '0;
        case (r_pat)
            PAT_HRAMP: w_pix = w_x[7:0];
            PAT_VRAMP: w_pix = w_y[7:0];
            PAT_CHECK: w_pix = (w_x[3] ^ w_y[3]) ? 8'hFF : 8'h00;
            PAT_LFSR:  w_pix = r_lfsr;
            default:   w_pix = '0;
        endcase
    end

    // Registered stream outputs; luma holds between strobes and is cleared while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_clken      <= 1'b0;
            r_img_y      <= '0;
            r_setx       <= '0;
            r_sety       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_vsync      <= w_vsync;
            r_href       <= w_act;
            r_clken      <= w_pix_en;
            r_setx       <= w_act ? w_x : '0;
            r_sety       <= w_act ? w_y : '0;
            r_frame_done <= r_clken && (r_setx == X_LAST) && (r_sety == Y_LAST);
            if (!w_run) begin
                r_img_y <= '0;
            end else if (w_pix_en) begin
                r_img_y <= w_pix;
            end
        end
    end

    // Pattern latch and LFSR: reseeded at each frame start, stepped after every pixel strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat  <= PAT_HRAMP;
            r_lfsr <= LFSR_SEED;
        end else if (w_frame_start) begin
            r_pat  <= pat_e'(pattern_sel);
            r_lfsr <= LFSR_SEED;
        end else if (w_pix_en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign post_frame_vsync = r_vsync;
    assign post_frame_href  = r_href;
    assign post_frame_clken = r_clken;
    assign post_img_Y       = r_img_y;
    assign post_setx        = r_setx;
    assign post_sety        = r_sety;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_video_stream_source.sv
// Bench for video_stream_source: two instances (pixel divider 1 and 3) against a raster model.
// Latency: model predicts the registered outputs one clock after the state it derives them from.
// Backpressure: n/a.
module tb_video_stream_source;

    localparam int HD = 8, VD = 4, HB = 4, VB = 3, VS = 1;
    localparam int HT = HD + HB, VT = VD + VB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] sel;

    logic [1:0]  vs, hr, ce, fd;
    logic [7:0]  y0, y1;
    logic [10:0] sx0, sx1;
    logic [9:0]  sy0, sy1;
    logic [32:0] vec [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    video_stream_source #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_BLANK(VB),
                          .VSYNC_LEN(VS), .CLKEN_DIV(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(sel),
        .post_frame_vsync(vs[0]), .post_frame_href(hr[0]), .post_frame_clken(ce[0]),
        .post_img_Y(y0), .post_setx(sx0), .post_sety(sy0), .frame_done(fd[0]));

    video_stream_source #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_BLANK(VB),
                          .VSYNC_LEN(VS), .CLKEN_DIV(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(sel),
        .post_frame_vsync(vs[1]), .post_frame_href(hr[1]), .post_frame_clken(ce[1]),
        .post_img_Y(y1), .post_setx(sx1), .post_sety(sy1), .frame_done(fd[1]));

    assign vec[0] = {vs[0], hr[0], ce[0], y0, sx0, sy0, fd[0]};
    assign vec[1] = {vs[1], hr[1], ce[1], y1, sx1, sy1, fd[1]};

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out, awaited event never occurred", name);
    endtask

    // ---------------- behavioural model ----------------
    // Raster position is a single tick index n within the frame; h = n % HT, v = n / HT.
    bit          m_run  [2];
    int          m_n    [2];
    int          m_c    [2];
    logic [1:0]  m_pat  [2];
    logic [7:0]  m_lfsr [2];
    logic [7:0]  m_y    [2];
    bit          m_last [2];
    logic [32:0] exp_vec[2];
    int          cyc = 0;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic [7:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ ((8'd1 << 7) | (8'd1 << 5) | (8'd1 << 4) | (8'd1 << 3));
        return r;
    endfunction

    function automatic logic [7:0] pixel(input int x, input int y, input logic [1:0] p, input logic [7:0] l);
        case (p)
            2'd0:    return 8'(x % 256);
            2'd1:    return 8'(y % 256);
            2'd2:    return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: return l;
        endcase
    endfunction

    task automatic model_reset(input int d);
        m_run[d] = 0; m_n[d] = 0; m_c[d] = 0; m_pat[d] = 2'd0;
        m_lfsr[d] = 8'hA5; m_y[d] = 8'h00; m_last[d] = 0; exp_vec[d] = '0;
    endtask

    task automatic model_step(input int d);
        int  div, h, v;
        bit  tick, vsx, act, pe, done;
        div  = (d == 0) ? 1 : 3;
        tick = (m_c[d] % div) == div - 1;
        h = m_n[d] % HT;
        v = m_n[d] / HT;
        vsx  = m_run[d] && v < VS;
        act  = m_run[d] && v >= VB && h < HD;
        pe   = act && tick;
        done = m_last[d];
        if (!m_run[d]) m_y[d] = 8'h00;
        else if (pe) begin
            m_y[d]    = pixel(h, v - VB, m_pat[d], m_lfsr[d]);
            m_lfsr[d] = lfsr_step(m_lfsr[d]);
        end
        m_last[d]  = pe && h == HD - 1 && (v - VB) == VD - 1;
        exp_vec[d] = {vsx, act, pe, m_y[d], act ? 11'(h) : 11'd0, act ? 10'(v - VB) : 10'd0, done};
        if (tick) begin
            if (!m_run[d]) begin
                if (enable) begin
                    m_run[d] = 1; m_n[d] = 0; m_pat[d] = sel; m_lfsr[d] = 8'hA5;
                end
            end else begin
                m_n[d]++;
                if (m_n[d] == HT * VT) begin
                    m_n[d] = 0;
                    if (enable) begin
                        m_pat[d] = sel; m_lfsr[d] = 8'hA5;
                    end else begin
                        m_run[d] = 0;
                    end
                end
            end
        end
        m_c[d]++;
    endtask

    // Compare process: on each falling edge check both DUTs, then advance the model one clock.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) model_reset(d);
                n_cmp++;
                if (vec[d] !== exp_vec[d]) begin
                    n_err++;
                    $display("FAIL stream dut%0d cyc %0d: got %h, expected %h", d, cyc, vec[d], exp_vec[d]);
                end
                if (rst_n) model_step(d);
            end
        end
    end

    // ---------------- per-frame statistics (frame = vsync rise to vsync rise) ----------------
    int rises[2], rise_t[2], c_vs[2], c_b[2], c_ce[2], c_fd[2], run_len[2], c_max[2], tot_fd[2];
    int l_period[2], l_vs[2], l_b[2], l_ce[2], l_fd[2], l_max[2];
    bit pvs[2], phr[2];
    logic [7:0] cur_seq [32];
    logic [7:0] last_seq[32];
    logic [7:0] prev_seq[32];
    logic [7:0] cur_or, l_or;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rises[d] = 0; tot_fd[d] = 0; pvs[d] = 0; phr[d] = 0; run_len[d] = 0;
            c_vs[d] = 0; c_b[d] = 0; c_ce[d] = 0; c_fd[d] = 0; c_max[d] = 0;
        end
        cur_or = 0; l_or = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (vs[d] && !pvs[d]) begin
                    if (rises[d] > 0) begin
                        l_period[d] = cyc - rise_t[d]; l_vs[d] = c_vs[d]; l_b[d] = c_b[d];
                        l_ce[d] = c_ce[d]; l_fd[d] = c_fd[d]; l_max[d] = c_max[d];
                        if (d == 0) begin
                            prev_seq = last_seq; last_seq = cur_seq; l_or = cur_or;
                        end
                    end
                    rise_t[d] = cyc; rises[d]++;
                    c_vs[d] = 0; c_b[d] = 0; c_ce[d] = 0; c_fd[d] = 0; c_max[d] = 0;
                    if (d == 0) cur_or = 0;
                end
                if (vs[d]) c_vs[d]++;
                if (hr[d] && !phr[d]) c_b[d]++;
                if (hr[d]) run_len[d]++;
                else begin
                    if (run_len[d] > c_max[d]) c_max[d] = run_len[d];
                    run_len[d] = 0;
                end
                if (ce[d]) begin
                    if (d == 0) begin
                        if (c_ce[d] < 32) cur_seq[c_ce[d]] = y0;
                        cur_or = cur_or | y0;
                    end
                    c_ce[d]++;
                end
                if (fd[d]) begin c_fd[d]++; tot_fd[d]++; end
                pvs[d] = vs[d]; phr[d] = hr[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rise(input int d, input int limit, input string name);
        int r0;
        int k;
        r0 = rises[d];
        k = 0;
        while (rises[d] == r0 && k < limit) begin clks(1); k++; end
        if (rises[d] == r0) fail_timeout(name);
    endtask

    // which: 0 = href, 1 = href on active line 1, 2 = any of vsync/href (all on the divide-by-1 DUT)
    task automatic wait_sig(input int which, input int limit, input string name);
        int k;
        bit hit;
        k = 0;
        hit = 0;
        while (!hit && k < limit) begin
            case (which)
                0:       hit = hr[0];
                1:       hit = hr[0] && sy0 == 10'd1;
                default: hit = vs[0] || hr[0];
            endcase
            if (!hit) begin clks(1); k++; end
        end
        if (!hit) fail_timeout(name);
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; sel = 2'd0;
        #1 rst_n = 1'b0;
        clks(3);
        check("reset_dut0", vec[0], 33'd0);
        check("reset_dut1", vec[1], 33'd0);

        // Steady ramp frames on both dividers.
        rst_n = 1'b1; enable = 1'b1; sel = 2'd0;
        clks(800);
        check("d1_period",  33'(l_period[0]), 33'd84);
        check("d1_vsync",   33'(l_vs[0]),     33'd12);
        check("d1_bursts",  33'(l_b[0]),      33'd4);
        check("d1_href_len",33'(l_max[0]),    33'd8);
        check("d1_clken",   33'(l_ce[0]),     33'd32);
        check("d1_done",    33'(l_fd[0]),     33'd1);
        check("d1_y_x7",    33'(last_seq[7]), 33'd7);
        check("d3_period",  33'(l_period[1]), 33'd252);
        check("d3_href_len",33'(l_max[1]),    33'd24);
        check("d3_clken",   33'(l_ce[1]),     33'd32);
        check("d3_done",    33'(l_fd[1]),     33'd1);

        // LFSR pattern: seeded identically every frame.
        sel = 2'd3;
        clks(84 * 3 + 10);
        check("lfsr_y0", 33'(last_seq[0]), 33'h0A5);
        check("lfsr_y1", 33'(last_seq[1]), 33'h0EA);
        check("lfsr_y2", 33'(last_seq[2]), 33'h075);
        check("lfsr_y3", 33'(last_seq[3]), 33'h082);
        begin
            bit same;
            same = 1;
            for (int i = 0; i < 32; i++) if (last_seq[i] !== prev_seq[i]) same = 0;
            check("lfsr_repeat", 33'(same), 33'd1);
        end

        // Pattern change mid-frame only affects the following frame.
        sel = 2'd0;
        wait_rise(0, 200, "wait_ramp_frame");
        wait_sig(0, 200, "wait_href_ramp");
        sel = 2'd2;
        wait_rise(0, 200, "wait_end_ramp");
        check("chg_ramp_x5",  33'(last_seq[5]),  33'd5);
        check("chg_ramp_x7",  33'(last_seq[31]), 33'd7);
        wait_rise(0, 200, "wait_end_check");
        check("chg_check_or", 33'(l_or),    33'd0);
        check("chg_check_ce", 33'(l_ce[0]), 33'd32);

        // Enable dropped during line 1: frame completes, then idle.
        wait_rise(0, 200, "wait_frame_e0");
        wait_sig(1, 200, "wait_line1");
        enable = 1'b0;
        begin
            int t0;
            t0 = tot_fd[0];
            clks(300);
            check("drop_one_done", 33'(tot_fd[0] - t0), 33'd1);
        end
        check("idle_dut0", vec[0], 33'd0);
        check("idle_dut1", vec[1], 33'd0);
        enable = 1'b1;
        wait_sig(2, 20, "wait_restart");
        check("restart_vsync_first", {31'd0, vs[0], hr[0]}, 33'b10);

        // Random enable / pattern activity, checked every clock by the model.
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) < 8);
            clks($urandom_range(1, 150));
        end

        // Reset mid-line: outputs clear without waiting for a clock.
        enable = 1'b1;
        wait_sig(0, 600, "wait_href_rst");
        rst_n = 1'b0;
        #1;
        check("async_rst_dut0", vec[0], 33'd0);
        check("async_rst_dut1", vec[1], 33'd0);
        clks(3);
        rst_n = 1'b1;
        wait_sig(2, 20, "wait_after_rst");
        check("rst_vsync_first", {31'd0, vs[0], hr[0]}, 33'b10);
        clks(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
